// File: rtl/dispatch_arbiter.sv
// Round-robin dispatch arbiter feeding an external RAM used as a circular FIFO.
// Optional status print: define DISPATCH_ARBITER_REPORT_EN.
module dispatch_arbiter #(
    parameter int CORE        = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 3,
    parameter int NUM_REQ     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          deq,
    output logic                          deq_valid,
    output logic [DATA_WIDTH-1:0]         deq_data,
    output logic                          ram_write,
    output logic [INDEX_WIDTH-1:0]        ram_in_address,
    output logic [DATA_WIDTH-1:0]         ram_in_data,
    output logic                          ram_read,
    output logic [INDEX_WIDTH-1:0]        ram_out_address,
    input  logic [DATA_WIDTH-1:0]         ram_out_data,
    output logic                          full,
    output logic                          empty,
    output logic [INDEX_WIDTH:0]          count,
    input  logic                          report
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = INDEX_WIDTH + 1;

    logic [INDEX_WIDTH-1:0] wr_ptr;
    logic [INDEX_WIDTH-1:0] rd_ptr;
    logic [PW-1:0]          prio;
    logic [PW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic                   deq_acc;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pick the first requester at or after prio; nothing accepted while full or in reset.
    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        gnt_idx     = '0;
        gnt_any     = 1'b0;
        ram_in_data = '0;
        if (reset && !full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(prio) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!gnt_any && req[j]) begin
                    gnt_any     = 1'b1;
                    gnt_idx     = PW'(j);
                    grant[j]    = 1'b1;
                    ram_in_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign deq_acc         = reset && deq && !empty;
    assign ram_write       = gnt_any;
    assign ram_in_address  = wr_ptr;
    assign ram_read        = deq_acc;
    assign ram_out_address = rd_ptr;
    assign deq_data        = ram_out_data;

    // FIFO pointers, occupancy, arbitration priority and read-valid pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= '0;
            deq_valid <= 1'b0;
        end else begin
            deq_valid <= deq_acc;
            if (gnt_any) begin
                wr_ptr <= wr_ptr + 1'b1;
                prio   <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (deq_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({gnt_any, deq_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DISPATCH_ARBITER_REPORT_EN
    logic [31:0] cycle;

    // Free-running cycle counter and status print on request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 1'b1;
            if (report)
                $display("core=%0d cycle=%0d wr_ptr=%0d rd_ptr=%0d count=%0d prio=%0d grant=%b full=%b empty=%b",
                         CORE, cycle, wr_ptr, rd_ptr, count, prio, grant, full, empty);
        end
    end
`else
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);
`endif

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed bench for dispatch_arbiter with a behavioural synchronous RAM.
// Defaults: 4 requesters, depth 8, 32-bit words.
module tb_dispatch_arbiter;

    localparam int DW = 32;
    localparam int IW = 3;
    localparam int NR = 4;

    logic          clock;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] grant;
    logic          deq;
    logic          deq_valid;
    logic [DW-1:0] deq_data;
    logic          ram_write;
    logic [IW-1:0] ram_in_address;
    logic [DW-1:0] ram_in_data;
    logic          ram_read;
    logic [IW-1:0] ram_out_address;
    logic [DW-1:0] ram_out_data;
    logic          full;
    logic          empty;
    logic [IW:0]   count;
    logic          report;

    logic [DW-1:0] mem [0:(1<<IW)-1];

    int vectors = 0;
    int errors  = 0;

    dispatch_arbiter #(
        .CORE(0), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .NUM_REQ(NR)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .deq(deq), .deq_valid(deq_valid), .deq_data(deq_data),
        .ram_write(ram_write), .ram_in_address(ram_in_address),
        .ram_in_data(ram_in_data), .ram_read(ram_read),
        .ram_out_address(ram_out_address), .ram_out_data(ram_out_data),
        .full(full), .empty(empty), .count(count), .report(report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: write at edge, read data valid the cycle after ram_read.
    always @(posedge clock) begin
        if (ram_write) mem[ram_in_address] <= ram_in_data;
        if (ram_read) ram_out_data <= mem[ram_out_address];
    end

    task automatic apply_reset();
        @(posedge clock);
        #2;
        req = '0;
        deq = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        deq = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full);
        end
        vectors++;
        if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b exp 0", deq_valid); end
        vectors++;
        if (grant !== 4'b0000 || ram_write !== 1'b0 || ram_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got grant=%b wr=%b rd=%b exp 0000/0/0", grant, ram_write, ram_read);
        end
        req = '0;
        deq = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] eg;
        logic [IW-1:0] ea;
        for (int j = 0; j < NR; j++) req_data[j*DW +: DW] = 32'h100 + j;
        req = 4'b1111;
        deq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eg = 4'b0001 << (i % 4);
            ea = 3'(i);
            #1;
            vectors++;
            if (grant !== eg || ram_write !== 1'b1 || ram_in_address !== ea ||
                ram_in_data !== 32'h100 + (i % 4)) begin
                errors++;
                $display("FAIL rr_grant[%0d] got grant=%b addr=%0d data=%h exp %b/%0d/%h",
                         i, grant, ram_in_address, ram_in_data, eg, ea, 32'h100 + (i % 4));
            end
            @(posedge clock);
            #1;
            vectors++;
            if (count !== 4'(i + 1)) begin
                errors++; $display("FAIL rr_count[%0d] got %0d exp %0d", i, count, i + 1);
            end
        end
        #1;
        vectors++;
        if (full !== 1'b1 || empty !== 1'b0 || grant !== 4'b0000 || ram_write !== 1'b0) begin
            errors++;
            $display("FAIL rr_full got full=%b empty=%b grant=%b wr=%b exp 1/0/0000/0",
                     full, empty, grant, ram_write);
        end
    endtask

    task automatic test_full_deq();
        req = 4'b1111;
        deq = 1'b1;
        #1;
        vectors++;
        if (grant !== 4'b0000 || ram_read !== 1'b1 || ram_out_address !== 3'd0) begin
            errors++;
            $display("FAIL full_deq_comb got grant=%b rd=%b addr=%0d exp 0000/1/0",
                     grant, ram_read, ram_out_address);
        end
        @(posedge clock);
        #1;
        req = '0;
        deq = 1'b0;
        vectors++;
        if (count !== 4'd7 || deq_valid !== 1'b1 || deq_data !== 32'h100) begin
            errors++;
            $display("FAIL full_deq_out got count=%0d dv=%b data=%h exp 7/1/00000100",
                     count, deq_valid, deq_data);
        end
    endtask

    task automatic test_wrap();
        logic [IW-1:0] ea;
        for (int k = 0; k <= 10; k++) begin
            req = (k < 10) ? 4'b0100 : 4'b0000;
            req_data[2*DW +: DW] = 32'hA0 + k;
            deq = (k > 0);
            #1;
            if (k < 10) begin
                ea = 3'(k);
                vectors++;
                if (grant !== 4'b0100 || ram_in_address !== ea) begin
                    errors++;
                    $display("FAIL wrap_wr[%0d] got grant=%b addr=%0d exp 0100/%0d", k, grant, ram_in_address, ea);
                end
            end
            if (k > 0) begin
                ea = 3'(k - 1);
                vectors++;
                if (ram_read !== 1'b1 || ram_out_address !== ea) begin
                    errors++;
                    $display("FAIL wrap_rd[%0d] got rd=%b addr=%0d exp 1/%0d", k, ram_read, ram_out_address, ea);
                end
            end
            @(posedge clock);
            #1;
            if (k > 0) begin
                vectors++;
                if (deq_valid !== 1'b1 || deq_data !== 32'hA0 + k - 1) begin
                    errors++;
                    $display("FAIL wrap_data[%0d] got dv=%b data=%h exp 1/%h", k, deq_valid, deq_data, 32'hA0 + k - 1);
                end
            end
        end
        req = '0;
        deq = 1'b0;
        vectors++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL wrap_end got count=%0d empty=%b exp 0/1", count, empty);
        end
    endtask

    task automatic test_empty_deq();
        req = '0;
        deq = 1'b1;
        #1;
        vectors++;
        if (ram_read !== 1'b0) begin errors++; $display("FAIL empty_deq_rd got %b exp 0", ram_read); end
        @(posedge clock);
        #1;
        deq = 1'b0;
        vectors++;
        if (deq_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_deq_out got dv=%b count=%0d empty=%b exp 0/0/1", deq_valid, count, empty);
        end
    endtask

    task automatic test_prio_hold();
        logic [NR-1:0] seq_req [5];
        logic [NR-1:0] seq_exp [5];
        seq_req = '{4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b1001};
        seq_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            req = seq_req[i];
            #1;
            vectors++;
            if (grant !== seq_exp[i]) begin
                errors++; $display("FAIL prio[%0d] got %b exp %b", i, grant, seq_exp[i]);
            end
            @(posedge clock);
            #1;
        end
        req = '0;
    endtask

    task automatic test_back_to_back();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
        end
        vectors++;
        if (count !== 4'd3) begin errors++; $display("FAIL b2b_fill got %0d exp 3", count); end
        deq = 1'b1;
        #1;
        @(posedge clock);
        #1;
        req = '0;
        deq = 1'b0;
        vectors++;
        if (count !== 4'd3 || deq_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_same got count=%0d dv=%b exp 3/1", count, deq_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got count=%0d empty=%b full=%b dv=%b exp 0/1/0/0",
                     count, empty, full, deq_valid);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        deq      = 1'b0;
        report   = 1'b0;
        test_reset();
        test_round_robin();
        test_full_deq();
        apply_reset();
        test_wrap();
        test_empty_deq();
        apply_reset();
        test_prio_hold();
        apply_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_arbiter.md
DISPATCH_ARBITER -- requirements
Module: dispatch_arbiter

Interface
REQ-001 Parameters SHALL be: CORE, default 0, core index used in report output.
REQ-002 Parameters SHALL be: DATA_WIDTH, default 32, dispatch word width.
REQ-003 Parameters SHALL be: INDEX_WIDTH, default 3, RAM address width; DEPTH = 2^INDEX_WIDTH.
REQ-004 Parameters SHALL be: NUM_REQ, default 4, number of requesters, minimum 2.
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester enqueue request.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 grant  output  NUM_REQ  one-hot accept, combinational; word accepted at this edge.
REQ-010 deq  input  1  consumer dequeue request.
REQ-011 deq_valid  output  1  registered; deq_data valid this cycle.
REQ-012 deq_data  output  DATA_WIDTH  passthrough of ram_out_data.
REQ-013 ram_write, ram_in_address, ram_in_data  output  1/INDEX_WIDTH/DATA_WIDTH  dispatch RAM write port.
REQ-014 ram_read, ram_out_address  output  1/INDEX_WIDTH  dispatch RAM read port.
REQ-015 ram_out_data  input  DATA_WIDTH  RAM read data, valid one cycle after ram_read.
REQ-016 full, empty  output  1 each  registered-state flags from count.
REQ-017 count  output  INDEX_WIDTH+1  stored entries, 0..DEPTH.
REQ-018 report  input  1  status print strobe.

Function
REQ-019 The block SHALL manage the dispatch RAM as a circular FIFO using wr_ptr, rd_ptr (INDEX_WIDTH bits, wrap DEPTH-1 -> 0) and count.
REQ-020 Arbitration SHALL be round-robin: search starts at prio pointer, first asserted req wins; grant at most one bit per cycle.
REQ-021 grant SHALL be all-zero when full is 1, regardless of a same-cycle deq.
REQ-022 After grant to i, prio SHALL become (i+1) mod NUM_REQ; with no grant, prio SHALL hold.
REQ-023 When granting i: ram_write=1, ram_in_address=wr_ptr, ram_in_data=req_data slice i, same cycle; wr_ptr increments at edge.
REQ-024 deq with empty=0: ram_read=1, ram_out_address=rd_ptr, same cycle; rd_ptr increments at edge; deq_valid=1 next cycle.
REQ-025 deq with empty=1 SHALL be ignored: no ram_read, no pointer change, deq_valid=0 next cycle.
REQ-026 Simultaneous accepted write and read SHALL leave count unchanged; write-only +1; read-only -1.
REQ-027 full = (count==DEPTH); empty = (count==0); never both 1.
REQ-028 Read and write to the same address in one cycle SHALL occur only when count==DEPTH... (forbidden by REQ-021), so no RAM bypass is required.
REQ-029 ram_write and ram_read SHALL be 0 in any cycle without accepted grant/deq respectively.

Reset
REQ-030 On reset low, immediately: wr_ptr, rd_ptr, count, prio = 0; deq_valid = 0; empty=1, full=0; grant=0, ram_write=0, ram_read=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries and any in-flight read; RAM contents are not cleared.
REQ-032 First edge after reset release SHALL be a normal operating cycle.

Configuration
REQ-033 Macro DISPATCH_ARBITER_REPORT_EN defined: a 32-bit cycle counter (0 on reset) SHALL run, and report=1 SHALL $display CORE, cycle, wr_ptr, rd_ptr, count, prio, grant, full, empty each edge.
REQ-034 Macro undefined: no cycle counter or display logic SHALL exist; report is ignored; functional behaviour identical.

Verification
REQ-035 NUM_REQ=4, reset, req=4'b1111 held, deq=0 -> grants 0001,0010,0100,1000,0001... one per cycle; full=1 after 8 cycles, then grant=0.
REQ-036 Full FIFO, deq=1 and req=1111 same cycle -> grant=0, count 8->7, deq_valid=1 next cycle with first written word.
REQ-037 Write 0xA0..0xA9 from requester 2 interleaved with deq -> deq_data sequence 0xA0..0xA9, pointers wrap 7->0, no loss.
REQ-038 Empty FIFO, deq=1 -> ram_read=0, deq_valid=0, count stays 0.
REQ-039 count=3 with one write and one read same cycle -> count stays 3; then reset low mid-cycle -> count=0, empty=1, deq_valid=0 without clock edge.
